// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit accumulator CPU: opcodes, HLT encoding,
// controller state encoding and accumulator source select codes.
package cpu_pkg;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LDI  = 3'b001;
    localparam logic [2:0] OP_ADDI = 3'b010;
    localparam logic [2:0] OP_SUBI = 3'b011;
    localparam logic [2:0] OP_LDA  = 3'b100;
    localparam logic [2:0] OP_STA  = 3'b101;
    localparam logic [2:0] OP_JMP  = 3'b110;
    localparam logic [2:0] OP_JZ   = 3'b111;

    // HLT lives in the NOP opcode space
    localparam logic [7:0] HLT = 8'b0001_1111;

    localparam logic [1:0] ACC_SRC_IMM = 2'b00;
    localparam logic [1:0] ACC_SRC_ALU = 2'b01;
    localparam logic [1:0] ACC_SRC_MEM = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_MEM   = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    function automatic logic is_hlt(input logic [7:0] instr);
        return instr == HLT;
    endfunction

endpackage

// File: rtl/cpu_ctrl_wdt.sv
// Memory-wait watchdog: counts cycles while enabled, flags expiry once the
// count reaches TIMEOUT.
module cpu_ctrl_wdt #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT);

    logic [7:0] count;

    // Saturates so a stuck enable can never wrap back below the limit
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= 8'd0;
        end else if (en && count != 8'hFF) begin
            count <= count + 8'd1;
        end
    end

    assign expired = count >= LIMIT;

endmodule

// File: rtl/cpu_ctrl.sv
// Multi-cycle control sequencer for the accumulator CPU: fetch/exec/mem FSM,
// run/step gating, HLT handling and memory-wait watchdog.
module cpu_ctrl #(
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       step,
    input  logic [7:0] ir,
    input  logic       acc_zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       addr_sel,
    output logic       ir_load,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       acc_load,
    output logic [1:0] acc_src,
    output logic       alu_op,
    output logic       instr_done,
    output logic       halted,
    output logic       bus_err,
    output logic [2:0] state_o
);
    import cpu_pkg::*;

    state_t     state, next_state;
    logic       step_mode;
    logic       halted_q, bus_err_q;
    logic       in_mem_phase, wdt_expired, timeout_hit, halt_now;
    logic [2:0] opcode;
    state_t     retire_state;

    assign opcode       = ir[7:5];
    assign in_mem_phase = (state == S_FETCH) || (state == S_MEM);
    assign timeout_hit  = in_mem_phase && !mem_ready && wdt_expired;
    assign halt_now     = ((state == S_EXEC) && is_hlt(ir)) || timeout_hit;
    assign retire_state = (run && !step_mode) ? S_FETCH : S_IDLE;

    // Counter sits at zero outside FETCH/MEM, so entry into either starts fresh
    cpu_ctrl_wdt #(.TIMEOUT(TIMEOUT)) u_wdt (
        .clk     (clk),
        .reset   (reset),
        .clr     (!in_mem_phase || mem_ready),
        .en      (1'b1),
        .expired (wdt_expired)
    );

    always_comb begin
        next_state = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        addr_sel   = 1'b0;
        ir_load    = 1'b0;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        acc_load   = 1'b0;
        acc_src    = ACC_SRC_IMM;
        alu_op     = 1'b0;
        instr_done = 1'b0;
        case (state)
            S_IDLE: begin
                if (run || step) next_state = S_FETCH;
            end
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_load    = 1'b1;
                    pc_inc     = 1'b1;
                    next_state = S_EXEC;
                end else if (wdt_expired) begin
                    next_state = S_HALT;
                end
            end
            S_EXEC: begin
                if (is_hlt(ir)) begin
                    instr_done = 1'b1;
                    next_state = S_HALT;
                end else if (opcode == OP_LDA || opcode == OP_STA) begin
                    next_state = S_MEM;
                end else begin
                    instr_done = 1'b1;
                    next_state = retire_state;
                    case (opcode)
                        OP_LDI:  acc_load = 1'b1;
                        OP_ADDI: begin
                            acc_load = 1'b1;
                            acc_src  = ACC_SRC_ALU;
                        end
                        OP_SUBI: begin
                            acc_load = 1'b1;
                            acc_src  = ACC_SRC_ALU;
                            alu_op   = 1'b1;
                        end
                        OP_JMP:  pc_load = 1'b1;
                        OP_JZ:   pc_load = acc_zero;
                        default: ;
                    endcase
                end
            end
            S_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = (opcode == OP_STA);
                if (mem_ready) begin
                    if (opcode == OP_LDA) begin
                        acc_load = 1'b1;
                        acc_src  = ACC_SRC_MEM;
                    end
                    instr_done = 1'b1;
                    next_state = retire_state;
                end else if (wdt_expired) begin
                    next_state = S_HALT;
                end
            end
            S_HALT:  next_state = S_HALT;
            default: next_state = S_IDLE;
        endcase
    end

    // step_mode is captured only when leaving IDLE, so step pulses elsewhere do nothing
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            step_mode <= 1'b0;
            halted_q  <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state <= next_state;
            if (state == S_IDLE && (run || step)) step_mode <= !run;
            if (halt_now) halted_q <= 1'b1;
            if (timeout_hit) bus_err_q <= 1'b1;
        end
    end

    assign halted  = halted_q || halt_now;
    assign bus_err = bus_err_q || timeout_hit;
    assign state_o = state;

endmodule

// File: doc/cpu_ctrl.md
# cpu_ctrl

Multi-cycle control sequencer for the 8-bit accumulator CPU: sequences the PC, IR, accumulator and ALU through fetch/execute/memory states and drives the shared instruction/data memory handshake. Sits inside `cpu` between the datapath (pc, instr, acc) and the single-port memory. It adds run/step gating for bench and debug control, a halt instruction, and a memory-wait watchdog.

## Interface
- `TIMEOUT`, 15: max cycles `mem_req` may wait for `mem_ready` before bus error (1..255)
- `clk`  in  1  system clock, all state on rising edge
- `reset`  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- `run`  in  1  level; 1 = execute continuously
- `step`  in  1  one-cycle pulse; execute exactly one instruction from IDLE
- `ir`  in  8  instruction register contents from datapath (valid from cycle after `ir_load`)
- `acc_zero`  in  1  datapath flag, acc == 0
- `mem_ready`  in  1  memory completes current request this cycle
- `mem_req`  out  1  memory request
- `mem_we`  out  1  write (only with `mem_req`)
- `addr_sel`  out  1  0 = address from pc, 1 = address from `ir[4:0]`
- `ir_load`, `pc_inc`, `pc_load`, `acc_load`  out  1 each  datapath strobes
- `acc_src`  out  2  00 imm5 zero-extended, 01 ALU result, 10 memory read data
- `alu_op`  out  1  0 add, 1 sub
- `instr_done`  out  1  one-cycle pulse when an instruction retires
- `halted`  out  1  sticky; HLT executed or bus error
- `bus_err`  out  1  sticky; watchdog expired
- `state_o`  out  3  current state encoding (debug)

## Operation
- ISA: opcode `ir[7:5]`, operand `ir[4:0]`. 000 NOP, 001 LDI, 010 ADDI, 011 SUBI, 100 LDA, 101 STA, 110 JMP, 111 JZ. `8'b00011111` = HLT (NOP-space encoding).
- States: IDLE=0, FETCH=1, EXEC=2, MEM=3, HALT=4.
- IDLE: all strobes 0. `run`=1 or `step`=1 → FETCH. Latch `step_mode` = !run.
- FETCH: `mem_req`=1, `addr_sel`=0. On `mem_ready`: `ir_load`=1, `pc_inc`=1, → EXEC.
- EXEC (decode combinationally from `ir`):
  - NOP: retire.
  - LDI: `acc_load`, `acc_src`=00; retire.
  - ADDI/SUBI: `acc_load`, `acc_src`=01, `alu_op`=0/1; retire.
  - LDA/STA: → MEM.
  - JMP: `pc_load`; retire.
  - JZ: `pc_load` = `acc_zero`; retire.
  - HLT: → HALT, `instr_done` pulses.
- MEM: `mem_req`=1, `addr_sel`=1, `mem_we` = (STA). On `mem_ready`: LDA asserts `acc_load`, `acc_src`=10; retire.
- Retire: `instr_done`=1. Next state is FETCH if `run`=1 and not `step_mode`; otherwise IDLE.
- `run` falling mid-instruction: the instruction completes, then the block goes to IDLE. Instructions are never abandoned except by reset or bus error.
- `step` while not in IDLE: ignored.
- HALT: all strobes 0, `halted`=1. Exits only via reset.
- Watchdog: 8-bit counter, cleared on entry to FETCH/MEM and on `mem_ready`, increments each waiting cycle. When the count reaches `TIMEOUT` with no `mem_ready`: `bus_err`=1, `halted`=1, → HALT, `mem_req` dropped.

## Timing
- Outputs are decoded from state plus `ir` / `acc_zero` / `mem_ready`. Handshake strobes in FETCH/MEM are Mealy on `mem_ready`; no registered output delay.
- `mem_req` holds high until the cycle `mem_ready` is sampled. `mem_ready` outside FETCH/MEM is ignored.
- Zero-wait memory timing:
  - ALU, jump and NOP instructions: 2 cycles (FETCH, EXEC).
  - LDA/STA: 3 cycles.
  - Each memory wait cycle adds 1.
- Reset value of every output: 0; `state_o`=IDLE; watchdog=0. Reset takes effect at the next edge from any state, dropping a pending `mem_req`. The memory must tolerate an abandoned request.
- Priority when `run` and `step` are both high in IDLE: `run` wins (continuous mode).

## Structure
- Shared package `cpu_pkg`: opcode localparams (OP_NOP..OP_JZ), the `HLT` encoding, state encoding, and `acc_src` codes. The same package is used by the datapath and the bench.
- One natural sub-module: `cpu_ctrl_wdt` (watchdog counter with clear/enable, `TIMEOUT` parameter, `expired` output). Decode and FSM stay in `cpu_ctrl`.

## Test plan
- Reset, then `run`=1, zero-wait memory, program LDI 5 / ADDI 3 / SUBI 1 / HLT. Required:
  - `acc_load` asserts in cycles 2, 4, 6 after reset release.
  - `instr_done` pulses 4 times.
  - `halted`=1 at cycle 8 and stays.
- JZ taken vs. not taken: LDI 0 / JZ 7 → `pc_load`=1 in EXEC. LDI 1 / JZ 7 → `pc_load`=0, `pc_inc` only.
- LDA 9 with `mem_ready` delayed 3 cycles: `mem_req`=1 and `addr_sel`=1 held for 4 cycles, then `acc_load` with `acc_src`=10 in the cycle `mem_ready`=1. STA 9 gives `mem_we`=1 under the same timing.
- Step mode: `run`=0, `step` pulse → exactly one `instr_done`, then `state_o`=IDLE. A second `step` issued during FETCH is ignored.
- Watchdog: `TIMEOUT`=15, `mem_ready` held 0 in FETCH → `bus_err`=`halted`=1 after 15 wait cycles, `mem_req`=0 the following cycle.
- Reset asserted in MEM with `mem_req`=1 → next edge: all outputs 0, IDLE. After release with `run`=1, FETCH restarts.
